// File: rtl/structural_multiplexer.sv
// structural_multiplexer: gate-level 4:1 mux with registered copy; STRUCT_MUX_GATE_DELAY_EN adds #50 gate delays
`timescale 1ns/1ps
module structural_multiplexer #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic address0,
  input  logic address1,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic out,
  output logic out_q
);
  wire na0, na1, en0, en1, en2, en3, t0, t1, t2, t3;
`ifdef STRUCT_MUX_GATE_DELAY_EN
  not #50 (na0, address0);
  not #50 (na1, address1);
  and #50 (en0, na1, na0);
  and #50 (en1, na1, address0);
  and #50 (en2, address1, na0);
  and #50 (en3, address1, address0);
  and #50 (t0, en0, in0);
  and #50 (t1, en1, in1);
  and #50 (t2, en2, in2);
  and #50 (t3, en3, in3);
  or  #50 (out, t0, t1, t2, t3);
`else
  not (na0, address0);
  not (na1, address1);
  and (en0, na1, na0);
  and (en1, na1, address0);
  and (en2, address1, na0);
  and (en3, address1, address0);
  and (t0, en0, in0);
  and (t1, en1, in1);
  and (t2, en2, in2);
  and (t3, en3, in3);
  or  (out, t0, t1, t2, t3);
`endif
  // registered copy of the selected bit, forced to RESET_VAL on reset
  always_ff @(posedge clk)
    out_q <= reset ? RESET_VAL : out;
endmodule

// File: tb/tb_structural_multiplexer.sv
// tb_structural_multiplexer: directed vector bench for structural_multiplexer
`timescale 1ns/1ps
module tb_structural_multiplexer;
`ifdef STRUCT_MUX_GATE_DELAY_EN
  localparam int HP = 250;
  localparam int SETTLE = 200;
`else
  localparam int HP = 5;
  localparam int SETTLE = 1;
`endif
  typedef struct {
    logic a1;
    logic a0;
    logic [3:0] din;
    logic exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset, address0, address1, in0, in1, in2, in3;
  logic out, out_q;
  int passed = 0;
  int total = 0;
  vec_t vecs [16];
  structural_multiplexer #(.RESET_VAL(1'b0)) dut (
    .clk(clk), .reset(reset), .address0(address0), .address1(address1),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .out(out), .out_q(out_q)
  );
  always #HP clk = ~clk;
  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask
  task automatic drive(input logic a1, input logic a0, input logic [3:0] d);
    address1 = a1;
    address0 = a0;
    {in3, in2, in1, in0} = d;
  endtask
  initial begin
    vecs[0]  = '{1'b0, 1'b0, 4'b1110, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 4'b1111, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 4'b1101, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'b1111, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 4'b1011, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'b1111, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 4'b0111, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'b1111, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 4'b0001, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 4'b0010, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 4'b0100, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 4'b1000, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 4'b0000, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 4'b0001, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'b1000, 1'b0};
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'b0001);
    #SETTLE;
    @(posedge clk); #1;
    chk("reset_out_q", out_q, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].a1, vecs[i].a0, vecs[i].din);
      #SETTLE;
      chk($sformatf("out_v%0d", i), out, vecs[i].exp);
      @(posedge clk); #1;
      chk($sformatf("out_q_v%0d", i), out_q, vecs[i].exp);
    end
    drive(1'b1, 1'b1, 4'b1000);
    #SETTLE;
    @(posedge clk); #1;
    chk("out_q_pre_reset", out_q, 1'b1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'b0100);
    #SETTLE;
    chk("out_during_reset", out, 1'b1);
    @(posedge clk); #1;
    chk("out_q_mid_reset", out_q, 1'b0);
    reset = 1'b0;
    chk("out_q_hold_after_release", out_q, 1'b0);
    @(posedge clk); #1;
    chk("out_q_first_after_release", out_q, 1'b1);
    drive(1'b1, 1'b0, 4'b1011);
    #SETTLE;
    chk("out_between_edges", out, 1'b0);
    chk("out_q_between_edges", out_q, 1'b1);
    @(posedge clk); #1;
    chk("out_q_next_edge", out_q, 1'b0);
`ifdef STRUCT_MUX_GATE_DELAY_EN
    drive(1'b0, 1'b0, 4'b1000);
    #SETTLE;
    chk("delay_start", out, 1'b0);
    address1 = 1'b1;
    address0 = 1'b1;
    #40;
    chk("delay_not_yet", out, 1'b0);
    #111;
    chk("delay_settled_150", out, 1'b1);
    #100;
    chk("delay_stable", out, 1'b1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
